alu_cmd_engine: RTL

ALU_CMD_ENGINE -- requirements
Module: alu_cmd_engine

---
 rtl/alu_cmd_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_engine.sv
// Byte-stream command engine: parses opcode/reserved/length headers from a UART
// receive stream and either echoes the payload or returns a 32-bit ADD/MUL reduction.
module alu_cmd_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_OPC, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPND, S_RESULT, S_DISCARD
    } state_t;

    typedef enum logic [1:0] {K_ECHO, K_ADD, K_MUL, K_BAD} kind_t;

    localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(4);

    state_t                  state_q;
    kind_t                   kind_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic [31:0]             acc_q;
    logic [23:0]             op_q;
    logic                    first_q;
    logic [1:0]              ridx_q;
    logic                    rdy_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    m_valid_q;
    logic                    err_q;

    logic                    s_ready;
    logic                    s_fire;
    logic                    m_fire;
    logic [LEN_W-1:0]        cnt_inc;
    logic [LEN_W-1:0]        len_new;
    logic                    last_byte;
    logic [31:0]             op_full;
    logic [31:0]             acc_next;
    logic [1:0]              ridx_n;
    kind_t                   kind_new;

    assign s_fire    = s_axis_tvalid && s_ready;
    assign m_fire    = m_valid_q && m_axis_tready;
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign len_new   = {s_axis_tdata, len_q[DATA_WIDTH-1:0]};
    assign last_byte = (cnt_inc == len_q);
    assign op_full   = {s_axis_tdata, op_q};
    assign ridx_n    = ridx_q + 2'd1;

    // rdy_q keeps the input closed until the first edge after reset release.
    always_comb begin
        s_ready = 1'b0;
        if (rdy_q) begin
            unique case (state_q)
                S_OPC, S_RSVD, S_LEN_LO, S_LEN_HI, S_DISCARD: s_ready = 1'b1;
                S_ECHO:   s_ready = !m_valid_q || m_axis_tready;
                S_OPND:   s_ready = !m_valid_q;
                default:  s_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        acc_next = acc_q + op_full;
        if (first_q)
            acc_next = op_full;
        else if (kind_q == K_MUL)
            acc_next = acc_q * op_full;
    end

    always_comb begin
        unique case (s_axis_tdata)
            8'h10:   kind_new = K_ECHO;
            8'h11:   kind_new = K_ADD;
            8'h12:   kind_new = K_MUL;
            default: kind_new = K_BAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_OPC;
            kind_q    <= K_ECHO;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            op_q      <= '0;
            first_q   <= 1'b0;
            ridx_q    <= '0;
            rdy_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= 1'b0;
            if (m_fire)
                m_valid_q <= 1'b0;

            unique case (state_q)
                S_OPC: if (s_fire) begin
                    kind_q  <= kind_new;
                    cnt_q   <= LEN_W'(1);
                    state_q <= S_RSVD;
                end
                S_RSVD: if (s_fire) begin
                    cnt_q   <= cnt_inc;
                    state_q <= S_LEN_LO;
                end
                S_LEN_LO: if (s_fire) begin
                    len_q[DATA_WIDTH-1:0] <= s_axis_tdata;
                    cnt_q   <= cnt_inc;
                    state_q <= S_LEN_HI;
                end
                S_LEN_HI: if (s_fire) begin
                    len_q   <= len_new;
                    cnt_q   <= cnt_inc;
                    first_q <= 1'b1;
                    // Rejection rules are prioritised: bad length, bad opcode, bad operand framing.
                    if (len_new < HDR_LEN) begin
                        err_q   <= 1'b1;
                        state_q <= S_OPC;
                    end else if (kind_q == K_BAD ||
                                 (kind_q != K_ECHO && (len_new == HDR_LEN || len_new[1:0] != 2'd0))) begin
                        err_q   <= 1'b1;
                        state_q <= (len_new > HDR_LEN) ? S_DISCARD : S_OPC;
                    end else if (kind_q == K_ECHO) begin
                        state_q <= (len_new == HDR_LEN) ? S_OPC : S_ECHO;
                    end else begin
                        state_q <= S_OPND;
                    end
                end
                S_ECHO: if (s_fire) begin
                    m_data_q  <= s_axis_tdata;
                    m_valid_q <= 1'b1;
                    cnt_q     <= cnt_inc;
                    if (last_byte)
                        state_q <= S_OPC;
                end
                S_OPND: if (s_fire) begin
                    cnt_q <= cnt_inc;
                    // Header is 4 bytes, so the low count bits give the operand byte lane.
                    if (cnt_q[1:0] == 2'd3) begin
                        acc_q   <= acc_next;
                        first_q <= 1'b0;
                        if (last_byte) begin
                            m_data_q  <= acc_next[DATA_WIDTH-1:0];
                            m_valid_q <= 1'b1;
                            ridx_q    <= 2'd0;
                            state_q   <= S_RESULT;
                        end
                    end else begin
                        op_q[{cnt_q[1:0], 3'b000} +: DATA_WIDTH] <= s_axis_tdata;
                    end
                end
                S_RESULT: if (m_fire) begin
                    if (ridx_q == 2'd3) begin
                        state_q <= S_OPC;
                    end else begin
                        ridx_q    <= ridx_n;
                        m_data_q  <= acc_q[{ridx_n, 3'b000} +: DATA_WIDTH];
                        m_valid_q <= 1'b1;
                    end
                end
                S_DISCARD: if (s_fire) begin
                    cnt_q <= cnt_inc;
                    if (last_byte)
                        state_q <= S_OPC;
                end
                default: state_q <= S_OPC;
            endcase
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign busy_o        = (state_q != S_OPC);
    assign err_o         = err_q;

endmodule
